// File: rtl/cache_lookup_assoc.sv
// cache_lookup_assoc: fully-associative tag/data lookup with round-robin fill, in-place update, invalidate and flush
module cache_lookup_assoc #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  input  logic [AW-1:0] REQ_ADDR,
  output logic          RESP_VALID,
  output logic          RESP_HIT,
  output logic [DW-1:0] RESP_DATA,
  input  logic          WE,
  input  logic [AW-1:0] W_ADDR,
  input  logic [DW-1:0] W_DATA,
  input  logic          INV,
  input  logic          FLUSH,
  output logic [PW:0]   OCCUPANCY
);
  logic [DEPTH-1:0] valid, rm, wm;
  logic [AW-1:0] tags [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [DW-1:0] rdata;
  logic whit, do_inv, do_we;
  // tags are unique among valid entries, so match vectors are one-hot and an OR-select suffices
  always_comb begin
    rm = '0;
    wm = '0;
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rm[i] = valid[i] && (tags[i] == REQ_ADDR);
      wm[i] = valid[i] && (tags[i] == W_ADDR);
      rdata = rdata | (rm[i] ? mem[i] : '0);
    end
  end
  assign whit = |wm;
  assign do_inv = INV & ~FLUSH;
  assign do_we = WE & ~INV & ~FLUSH;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
      ptr <= '0;
      OCCUPANCY <= '0;
      RESP_VALID <= 1'b0;
      RESP_HIT <= 1'b0;
      RESP_DATA <= '0;
    end else begin
      RESP_VALID <= REQ_VALID;
      if (REQ_VALID) begin
        RESP_HIT <= |rm;
        RESP_DATA <= rdata;
      end
      if (FLUSH) begin
        valid <= '0;
        ptr <= '0;
        OCCUPANCY <= '0;
      end else if (do_inv) begin
        valid <= valid & ~wm;
        if (whit) OCCUPANCY <= OCCUPANCY - (PW+1)'(1);
      end else if (do_we && !whit) begin
        valid[ptr] <= 1'b1;
        ptr <= ptr + PW'(1);
        if (!valid[ptr]) OCCUPANCY <= OCCUPANCY + (PW+1)'(1);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (do_we) begin
      if (whit) begin
        for (int i = 0; i < DEPTH; i++)
          if (wm[i]) mem[i] <= W_DATA;
      end else begin
        tags[ptr] <= W_ADDR;
        mem[ptr] <= W_DATA;
      end
    end
  end
endmodule

// File: tb/tb_cache_lookup_assoc.sv
// tb_cache_lookup_assoc: scoreboard bench with a slot-table reference model for cache_lookup_assoc
module tb_cache_lookup_assoc;
  localparam int DEPTH = 4;
  logic CLK = 0, RST = 0;
  logic REQ_VALID = 0, WE = 0, INV = 0, FLUSH = 0;
  logic [31:0] REQ_ADDR = 0, W_ADDR = 0, W_DATA = 0;
  logic RESP_VALID, RESP_HIT;
  logic [31:0] RESP_DATA;
  logic [2:0] OCCUPANCY;

  always #5 CLK = ~CLK;

  cache_lookup_assoc #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .RESP_VALID(RESP_VALID), .RESP_HIT(RESP_HIT), .RESP_DATA(RESP_DATA),
    .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .INV(INV), .FLUSH(FLUSH),
    .OCCUPANCY(OCCUPANCY)
  );

  typedef struct packed {logic v; logic h; logic [31:0] d;} exp_t;
  exp_t q[$];
  exp_t e, x;
  logic m_val[DEPTH];
  logic [31:0] m_tag[DEPTH], m_dat[DEPTH];
  int m_ptr, ri, wi;
  int total = 0, bad = 0;

  function automatic int find(logic [31:0] a);
    for (int i = 0; i < DEPTH; i++) if (m_val[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic int count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_val[i]) n++;
    return n;
  endfunction

  // reference model: expected response captured from pre-edge table state, then the table is updated
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
      m_ptr = 0;
      q.delete();
    end else begin
      ri = find(REQ_ADDR);
      e.v = REQ_VALID;
      e.h = ri >= 0;
      e.d = ri >= 0 ? m_dat[ri] : 32'h0;
      q.push_back(e);
      wi = find(W_ADDR);
      if (FLUSH) begin
        for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
        m_ptr = 0;
      end else if (INV) begin
        if (wi >= 0) m_val[wi] = 0;
      end else if (WE) begin
        if (wi >= 0) m_dat[wi] = W_DATA;
        else begin
          m_val[m_ptr] = 1;
          m_tag[m_ptr] = W_ADDR;
          m_dat[m_ptr] = W_DATA;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, w, $time);
    end
  endtask

  always begin
    @(negedge CLK or posedge RST);
    #1;
    if (RST || q.size() == 0) begin
      chk("resp_valid_idle", 32'(RESP_VALID), 32'h0);
    end else begin
      x = q.pop_front();
      chk("resp_valid", 32'(RESP_VALID), 32'(x.v));
      if (x.v) begin
        chk("resp_hit", 32'(RESP_HIT), 32'(x.h));
        chk("resp_data", RESP_DATA, x.d);
      end
    end
    chk("occupancy", 32'(OCCUPANCY), RST ? 32'h0 : 32'(count()));
  end

  task automatic step(logic rv, logic [31:0] ra, logic we, logic [31:0] wa, logic [31:0] wd, logic inv, logic fl);
    @(negedge CLK);
    REQ_VALID = rv; REQ_ADDR = ra; WE = we; W_ADDR = wa; W_DATA = wd; INV = inv; FLUSH = fl;
  endtask

  initial begin
    #1 RST = 1;
    repeat (2) @(negedge CLK);
    #2 RST = 0;
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 32'hAAAA, 0, 0);
    step(0, 0, 1, 32'h100, 32'hBBBB, 0, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 32'(k), 32'(k * 32'h11), 0, 0);
    step(1, 32'h1, 0, 0, 0, 0, 0);
    step(1, 32'h5, 0, 0, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0, 0, 0);
    step(1, 32'h40, 1, 32'h40, 32'h7, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 32'h1234, 0, 0);
    step(0, 0, 0, 32'h100, 0, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 32'h5, 0, 1);
    step(1, 32'h200, 0, 0, 0, 0, 0);
    step(1, 32'h0, 1, 32'h0, 32'h99, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 32'h55, 0, 0);
    step(1, 32'h300, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #2 RST = 1;
    repeat (2) @(negedge CLK);
    #2 RST = 0;
    step(1, 32'h300, 0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    repeat (800)
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 9)), $urandom,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_lookup_assoc.md
Name: cache_lookup_assoc

Overview:
Parametrised fully-associative address-to-data lookup table for the RISC-V CPU memory path. It generalises the 32-entry shift-in lookup. Entries carry valid bits. A write to an address already present updates that entry in place, so the table never holds duplicate tags. New addresses are placed by a round-robin replacement pointer. Lookups are registered with a valid handshake, and the block supports flush and single-address invalidate.

Parameters:
AW, 32, address/tag width in bits
DW, 32, data width in bits
DEPTH, 32, number of entries; power of two, >= 2
PW, $clog2(DEPTH), pointer/index width (derived, not overridden)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  1  lookup request strobe
REQ_ADDR  in  AW  lookup address
RESP_VALID  out  1  lookup result valid, one cycle after REQ_VALID
RESP_HIT  out  1  address found among valid entries
RESP_DATA  out  DW  data of matching entry; 0 on miss
WE  in  1  write/fill strobe
W_ADDR  in  AW  write address (tag)
W_DATA  in  DW  write data
INV  in  1  invalidate the entry matching W_ADDR
FLUSH  in  1  clear all valid bits
OCCUPANCY  out  PW+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (async, RST=1): all valid bits 0, replacement pointer 0, OCCUPANCY 0, RESP_VALID 0, RESP_HIT 0, RESP_DATA 0. Tag and data arrays are not reset.
- Lookup: on the edge where REQ_VALID=1, the block compares REQ_ADDR against every valid tag and registers the result. On the next cycle RESP_VALID=1, RESP_HIT is the match result, and RESP_DATA is the matching entry's data, or 0 on a miss.
- Lookup idle: when REQ_VALID=0, RESP_VALID=0 next cycle. RESP_HIT and RESP_DATA hold their last values.
- Lookup uses read-before-write. The compare sees table state from before any same-edge WE, INV or FLUSH.
- Lookup with a valid entry at tag 0 hits normally; the valid bit, not a zero tag, marks emptiness.
- Write hit: WE=1 and W_ADDR matches a valid entry -> that entry's data is replaced. Pointer and OCCUPANCY are unchanged.
- Write miss: WE=1 and no match -> the entry at the pointer gets tag=W_ADDR, data=W_DATA, valid=1. Pointer increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- On a write miss, OCCUPANCY increments only if the overwritten entry was invalid, so it saturates at DEPTH. A miss when full evicts the oldest allocation (FIFO order).
- INV=1: the valid bit of the entry matching W_ADDR is cleared and OCCUPANCY decrements. No match -> no effect. The pointer never moves on INV.
- Priority on one edge: FLUSH > INV > WE. FLUSH clears all valid bits, sets the pointer to 0 and OCCUPANCY to 0, and ignores WE/INV. INV with WE on the same edge: INV acts, WE is dropped.
- Uniqueness invariant: at most one valid entry matches any address. Match vectors are therefore one-hot and data is selected by OR-reduction of masked entries (no priority chain).
- Lookups may be issued every cycle (full throughput, latency 1). Writes may also be issued every cycle.
- RST asserted mid-stream: a pending response is dropped (RESP_VALID=0 while RST=1 and on the first cycle after release). The table is empty after release.

Test Plan:
- Reset, then REQ_ADDR=0x0 -> next cycle RESP_VALID=1, RESP_HIT=0, RESP_DATA=0, OCCUPANCY=0.
- Write 0x100->0xAAAA, then 0x100->0xBBBB, then look up 0x100 -> HIT=1, DATA=0xBBBB, OCCUPANCY=1 (no duplicate entry).
- DEPTH=4: write tags 1..5 with data 0x11..0x55 -> OCCUPANCY=4. Lookup 1 misses; lookup 5 returns 0x55; lookup 2 returns 0x22.
- WE 0x40->0x7 and REQ 0x40 on the same edge -> response is a miss. A repeat REQ the next cycle -> HIT=1, DATA=0x7.
- INV 0x100 after fill -> OCCUPANCY decrements and lookup misses. FLUSH together with WE 0x200 -> OCCUPANCY=0 and 0x200 misses.
- Assert RST while REQ_VALID=1 with a pending hit -> RESP_VALID=0 immediately. After release, all lookups miss.
